// File: rtl/aud_recorder_if.sv
// SRAM write-port bundle between the audio recorder and the sample memory.
// The recorder drives the bus (master); the SRAM side only observes it (slave).
interface aud_recorder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] o_address;
    logic              o_wr;
    logic [ADDR_W-1:0] o_last_addr;

    modport master (
        output o_data,
        output o_address,
        output o_wr,
        output o_last_addr
    );

    modport slave (
        input o_data,
        input o_address,
        input o_wr,
        input o_last_addr
    );
endinterface

// File: rtl/aud_recorder.sv
// I2S left-channel capture: deserialises 16-bit ADC words clocked by the codec BCLK
// and writes one sample per LRC period to sequential SRAM addresses.
module aud_recorder #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_init_done,
    input  logic                  i_lrc,
    input  logic                  i_data,
    input  logic                  i_start,
    input  logic                  i_pause,
    input  logic                  i_stop,
    aud_recorder_if.master        wr_bus,
    output logic                  o_busy,
    output logic                  o_full,
    output logic [2:0]            o_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_lrc_prev;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_pause_pending;
    logic [ADDR_W-1:0] r_address;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_full;

    logic              w_frame_start;
    logic              w_last_bit;
    logic              w_at_end;
    logic [DATA_W-1:0] w_shift_next;

    assign w_frame_start = r_lrc_prev & ~i_lrc;
    assign w_last_bit    = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_at_end      = (r_address == MAX_ADDR);
    assign w_shift_next  = {r_shift[DATA_W-2:0], i_data};

    // Requests resolve stop > pause > start; a write in progress always completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_stop && !i_pause && i_start && i_init_done) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_stop)              w_next = S_IDLE;
                else if (i_pause)        w_next = S_PAUSE;
                else if (w_frame_start)  w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (i_stop)              w_next = S_IDLE;
                else if (w_last_bit)     w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_at_end || i_stop)                 w_next = S_IDLE;
                else if (r_pause_pending || i_pause)    w_next = S_PAUSE;
                else                                    w_next = S_WAIT;
            end
            S_PAUSE: begin
                if (i_stop)              w_next = S_IDLE;
                else if (i_pause)        w_next = S_PAUSE;
                else if (i_start)        w_next = S_WAIT;
            end
            default:                     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_lrc_prev      <= 1'b1;
            r_shift         <= '0;
            r_data          <= '0;
            r_bit_cnt       <= '0;
            r_pause_pending <= 1'b0;
            r_address       <= '0;
            r_last_addr     <= '0;
            r_full          <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_lrc_prev      <= i_lrc;
            // Pause during a word is remembered only until that word's write cycle.
            r_pause_pending <= (r_state == S_SHIFT) && (r_pause_pending || i_pause);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_WAIT) begin
                        r_address <= '0;
                        r_full    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_next == S_SHIFT) r_bit_cnt <= '0;
                end
                S_SHIFT: begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_next == S_WRITE) r_data <= w_shift_next;
                end
                S_WRITE: begin
                    r_last_addr <= r_address;
                    if (w_at_end) r_full    <= 1'b1;
                    else          r_address <= r_address + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_bus.o_data      = r_data;
    assign wr_bus.o_address   = r_address;
    assign wr_bus.o_wr        = (r_state == S_WRITE);
    assign wr_bus.o_last_addr = r_last_addr;
    assign o_busy             = (r_state != S_IDLE);
    assign o_full             = r_full;
    assign o_state            = r_state;

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: I2S frame driver, write scoreboard, frame tables and
// hand-built pause / full / stop / reset sequences.
module tb_aud_recorder;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 20;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd4;

    logic clk = 1'b0;
    logic i_rst_n, i_init_done, i_lrc, i_data, i_start, i_pause, i_stop;
    logic o_busy, o_full;
    logic [2:0] o_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    aud_recorder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    aud_recorder #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (20'd3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_init_done (i_init_done),
        .i_lrc       (i_lrc),
        .i_data      (i_data),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_stop      (i_stop),
        .wr_bus      (bus),
        .o_busy      (o_busy),
        .o_full      (o_full),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected {address, data}.
    always @(negedge clk) begin
        if (bus.o_wr === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.o_address, bus.o_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({bus.o_address, bus.o_data} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             bus.o_address, bus.o_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // Frame driver outputs
    int          fr_wr_n;
    int          fr_wr_t;
    logic [2:0]  fr_stop_state;
    logic        prev_lsb = 1'b0;
    logic [2:0]  rs_state;
    logic        rs_busy, rs_full, rs_wr;
    logic [15:0] rs_data;
    logic [19:0] rs_addr, rs_last;

    // One 32-BCLK LRC period: left word in slots 1..16 (one-bit I2S delay), right in 17..32.
    task automatic drive_frame(input logic [15:0] left, input logic [15:0] right,
                               input int pause_t, input int stop_t, input int rst_t);
        fr_wr_n = 0;
        fr_wr_t = -1;
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            if (bus.o_wr === 1'b1) begin
                fr_wr_n++;
                if (fr_wr_t < 0) fr_wr_t = t;
            end
            if (stop_t >= 0 && t == stop_t + 1) fr_stop_state = o_state;
            i_lrc = (t >= 16);
            if (t == 0)       i_data = prev_lsb;
            else if (t <= 16) i_data = left[16-t];
            else              i_data = right[32-t];
            i_pause = (t == pause_t);
            i_stop  = (t == stop_t);
            if (rst_t >= 0 && t == rst_t + 1) i_rst_n = 1'b1;
            if (t == rst_t) begin
                i_rst_n = 1'b0;
                #1;
                rs_state = o_state;  rs_busy = o_busy;         rs_full = o_full;
                rs_wr    = bus.o_wr; rs_data = bus.o_data;     rs_addr = bus.o_address;
                rs_last  = bus.o_last_addr;
            end
        end
        prev_lsb = right[0];
    endtask

    task automatic pulse_start();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); i_stop = 1'b1;
        @(negedge clk); i_stop = 1'b0;
    endtask

    task automatic push_exp(input logic [19:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic        exp_wr;
        logic [19:0] exp_addr;
        logic [19:0] exp_next;
        logic        exp_full;
        logic        exp_busy;
    } frame_vec_t;

    frame_vec_t vec [8];

    initial begin
        // rows 0..2: three ordinary frames; rows 3..7: fill a 4-word memory
        vec[0] = '{16'h0001, 16'h1234, 1'b1, 20'd0, 20'd1, 1'b0, 1'b1};
        vec[1] = '{16'h8000, 16'h1234, 1'b1, 20'd1, 20'd2, 1'b0, 1'b1};
        vec[2] = '{16'hFFFF, 16'h1234, 1'b1, 20'd2, 20'd3, 1'b0, 1'b1};
        vec[3] = '{16'h0F0F, 16'h1234, 1'b1, 20'd0, 20'd1, 1'b0, 1'b1};
        vec[4] = '{16'h3C3C, 16'h1234, 1'b1, 20'd1, 20'd2, 1'b0, 1'b1};
        vec[5] = '{16'h7E81, 16'h1234, 1'b1, 20'd2, 20'd3, 1'b0, 1'b1};
        vec[6] = '{16'hC001, 16'h1234, 1'b1, 20'd3, 20'd3, 1'b1, 1'b0};
        vec[7] = '{16'h9999, 16'h1234, 1'b0, 20'd0, 20'd3, 1'b1, 1'b0};

        i_rst_n = 1'b0; i_init_done = 1'b0; i_lrc = 1'b1; i_data = 1'b0;
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", o_state, ST_IDLE);
        check("reset_busy", o_busy, 0);
        check("reset_full", o_full, 0);
        check("reset_wr", bus.o_wr, 0);
        check("reset_data", bus.o_data, 0);
        check("reset_addr", bus.o_address, 0);
        check("reset_last", bus.o_last_addr, 0);

        // start without init_done is ignored
        i_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("noinit_busy", o_busy, 0);
            check("noinit_wr", bus.o_wr, 0);
        end
        i_init_done = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("init_busy", o_busy, 1);
        check("init_state", o_state, ST_WAIT);

        // single word: latency and address bookkeeping
        push_exp(20'd0, 16'hA5C3);
        drive_frame(16'hA5C3, 16'h0000, -1, -1, -1);
        check("a5c3_wr_count", fr_wr_n, 1);
        check("a5c3_latency", fr_wr_t, 17);
        check("a5c3_addr_after", bus.o_address, 1);
        check("a5c3_last_after", bus.o_last_addr, 0);

        // table: consecutive frames
        pulse_stop();
        pulse_start();
        check("restart_addr", bus.o_address, 0);
        for (int i = 0; i < 3; i++) begin
            if (vec[i].exp_wr) push_exp(vec[i].exp_addr, vec[i].left);
            drive_frame(vec[i].left, vec[i].right, -1, -1, -1);
            check("tbl_wr_count", fr_wr_n, vec[i].exp_wr);
            check("tbl_next_addr", bus.o_address, vec[i].exp_next);
            check("tbl_full", o_full, vec[i].exp_full);
            check("tbl_busy", o_busy, vec[i].exp_busy);
        end

        // pause mid-word: word still written, then held through paused frames
        pulse_stop();
        pulse_start();
        push_exp(20'd0, 16'h1111);
        drive_frame(16'h1111, 16'h4321, -1, -1, -1);
        push_exp(20'd1, 16'h2222);
        drive_frame(16'h2222, 16'h4321, 5, -1, -1);
        check("pause_wr_count", fr_wr_n, 1);
        check("pause_state", o_state, ST_PAUSE);
        check("pause_addr", bus.o_address, 2);
        check("pause_last", bus.o_last_addr, 1);
        for (int i = 0; i < 4; i++) begin
            drive_frame(16'hBEEF, 16'h4321, -1, -1, -1);
            check("paused_no_wr", fr_wr_n, 0);
        end
        check("paused_addr_held", bus.o_address, 2);
        pulse_start();
        check("resume_state", o_state, ST_WAIT);
        push_exp(20'd2, 16'h3333);
        drive_frame(16'h3333, 16'h4321, -1, -1, -1);
        check("resume_wr_count", fr_wr_n, 1);
        check("resume_addr", bus.o_address, 3);

        // table: fill to MAX_ADDR = 3, fifth frame must not write
        pulse_stop();
        pulse_start();
        for (int i = 3; i < 8; i++) begin
            if (vec[i].exp_wr) push_exp(vec[i].exp_addr, vec[i].left);
            drive_frame(vec[i].left, vec[i].right, -1, -1, -1);
            check("full_wr_count", fr_wr_n, vec[i].exp_wr);
            check("full_next_addr", bus.o_address, vec[i].exp_next);
            check("full_flag", o_full, vec[i].exp_full);
            check("full_busy", o_busy, vec[i].exp_busy);
        end
        check("full_last", bus.o_last_addr, 3);
        pulse_start();
        check("fresh_full_clear", o_full, 0);
        check("fresh_addr", bus.o_address, 0);
        check("fresh_busy", o_busy, 1);

        // stop at bit 9 discards the word and holds the address registers
        push_exp(20'd0, 16'h5A5A);
        drive_frame(16'h5A5A, 16'h0000, -1, -1, -1);
        drive_frame(16'hFFFF, 16'h0000, -1, 9, -1);
        check("stop_no_wr", fr_wr_n, 0);
        check("stop_idle_next", fr_stop_state, ST_IDLE);
        check("stop_busy", o_busy, 0);
        check("stop_last_held", bus.o_last_addr, 0);
        check("stop_addr_held", bus.o_address, 1);
        check("stop_data_held", bus.o_data, 16'h5A5A);

        // asynchronous reset at bit 9
        pulse_start();
        push_exp(20'd0, 16'h1357);
        drive_frame(16'h1357, 16'h0000, -1, -1, -1);
        push_exp(20'd1, 16'h2468);
        drive_frame(16'h2468, 16'h0000, -1, -1, -1);
        drive_frame(16'hFFFF, 16'h0000, -1, -1, 9);
        check("rst_no_wr", fr_wr_n, 0);
        check("rst_state", rs_state, ST_IDLE);
        check("rst_busy", rs_busy, 0);
        check("rst_full", rs_full, 0);
        check("rst_wr", rs_wr, 0);
        check("rst_data", rs_data, 0);
        check("rst_addr", rs_addr, 0);
        check("rst_last", rs_last, 0);
        check("rst_idle_after", o_state, ST_IDLE);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Captures ADC samples from the audio codec's I2S serial output once codec register initialisation has completed, then hands each 16-bit left-channel sample to the SRAM write port with an incrementing address.
- Sits directly downstream of the codec I2C initializer; that block's finished flag gates this one.
- The codec is configured as master, I2S format, 16-bit, so i_clk is the codec bit clock (BCLK) and i_lrc is ADCLRCK.

Parameters:
- DATA_W, 16, sample width in bits; equals the codec word length.
- ADDR_W, 20, SRAM word-address width.
- MAX_ADDR, 20'hFFFFF, last writable address; a write here ends recording with o_full.

Ports:
- i_clk  in  1  codec BCLK; all logic on posedge.
- i_rst_n  in  1  reset.
- i_init_done  in  1  codec initialisation complete (level).
- i_lrc  in  1  ADCLRCK; low = left channel.
- i_data  in  1  ADCDAT serial data, MSB first.
- i_start  in  1  start or resume request (level, sampled each cycle).
- i_pause  in  1  pause request.
- i_stop  in  1  stop request.
- o_data  out  DATA_W  captured sample; stable from o_wr until the next o_wr.
- o_address  out  ADDR_W  SRAM address of the current or next write.
- o_wr  out  1  one-cycle write strobe.
- o_last_addr  out  ADDR_W  address of the most recent completed write.
- o_busy  out  1  high in every state except S_IDLE.
- o_full  out  1  memory exhausted; sticky until the next fresh start.

Behaviour:
- Reset: i_rst_n is an asynchronous, active-low reset; clock is i_clk. Reset is asynchronous on assertion and may occur mid-shift; the partial sample is discarded.
- Reset values: state S_IDLE, o_data 0, o_address 0, o_wr 0, o_last_addr 0, o_busy 0, o_full 0, shift register 0, bit counter 0, lrc_prev 1.
- lrc_prev registers i_lrc every cycle. A left-frame start is a cycle where lrc_prev == 1 and i_lrc == 0.
- Request priority when several are high in one cycle: stop > pause > start.
- S_IDLE:
  - If i_start && i_init_done: o_address <= 0, o_full <= 0, go to S_WAIT.
  - i_start while !i_init_done is ignored.
- S_WAIT:
  - On left-frame start, go to S_SHIFT with bit counter 0. That edge carries the I2S one-bit delay slot and is not captured.
  - i_pause goes to S_PAUSE.
- S_SHIFT:
  - Each cycle: shift register <= {shift[DATA_W-2:0], i_data}, bit counter +1.
  - The MSB is captured on the first S_SHIFT cycle, one BCLK after the left-frame start.
  - After DATA_W captures, go to S_WRITE. The right channel and trailing BCLKs are ignored.
  - i_pause does not interrupt shifting; it is latched (pause_pending) and honoured in S_WRITE.
- S_WRITE (exactly one cycle):
  - o_data <= shift register; o_wr = 1 with o_address unchanged; o_last_addr <= o_address.
  - Next cycle: if o_address == MAX_ADDR, set o_full = 1 and go to S_IDLE with o_address unchanged. Otherwise o_address +1.
  - Then go to S_PAUSE if pause_pending or i_pause (pause_pending cleared), else to S_WAIT.
- S_PAUSE:
  - Hold all outputs.
  - i_start goes to S_WAIT with o_address preserved (resume). i_init_done is not rechecked.
- i_stop in any non-idle state goes to S_IDLE next cycle.
  - A partial sample is discarded and no write occurs.
  - o_address and o_last_addr are held, so software reads the recording length from o_last_addr.
- Latency: o_wr asserts DATA_W+1 cycles after the left-frame-start cycle.
- At most one write per LRC period.
- The address never wraps; MAX_ADDR is a hard end.

Test Plan:
- Reset, then i_start=1 with i_init_done=0 for 10 cycles -> o_busy stays 0, o_wr never asserts. Then i_init_done=1 -> o_busy=1 next cycle.
- Started recorder; drive an I2S left word 16'hA5C3 after an LRC falling edge -> o_wr pulses once 17 cycles after that edge, o_data=16'hA5C3, o_address=0 during the strobe, then o_address=1 and o_last_addr=0.
- Three consecutive frames with left words 16'h0001, 16'h8000, 16'hFFFF and right words 16'h1234 -> exactly three writes at addresses 0, 1, 2 with those values; the right-channel value never appears.
- Assert i_pause at bit 5 of the second sample -> that sample is still written at address 1, state is S_PAUSE, and no write occurs during 4 paused frames. i_start resumes -> next write goes to address 2.
- MAX_ADDR=3, record 5 frames -> writes to 0..3 only, o_full=1 after the write at 3, o_busy=0. A fresh i_start clears o_full and restarts at address 0.
- i_stop mid-shift (bit 9), and separately i_rst_n pulsed low mid-shift -> no o_wr, idle next cycle. After stop, o_last_addr is held; after reset, all outputs are at reset values.
